// File: rtl/fmap_unpacker_pkg.sv
// Shared definitions for the CNN layer blocks: stream FSM encoding and
// a clog2 helper that never returns a zero width.
package fmap_unpacker_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fmap_state_t;

  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_unpacker.sv
// Frame-to-pixel unpacker: latches a full R x C frame, then streams it one pixel per beat.
// Optional out_row/out_col coordinate ports are built when FMAP_UNPACK_COORD_EN is defined.
module fmap_unpacker
  import fmap_unpacker_pkg::*;
#(
  parameter int data_width = 32,
  parameter int R          = 3,
  parameter int C          = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [data_width*R*C-1:0]    data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef FMAP_UNPACK_COORD_EN
  output logic [clog2w(R)-1:0]         out_row,
  output logic [clog2w(C)-1:0]         out_col,
`endif
  output logic [data_width-1:0]        pixel_out,
  output logic                         out_last
);

  localparam int N  = R * C;
  localparam int IW = clog2w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  fmap_state_t                    state_q, state_d;
  logic [IW-1:0]                  idx_q;
  logic [N-1:0][data_width-1:0]   frame_q;
  logic                           load, fire, at_last;

  assign at_last   = (idx_q == LAST_IDX);
  assign pixel_out = frame_q[idx_q];

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    load      = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready) begin
          fire = 1'b1;
          if (at_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffer only loads in IDLE, so input traffic during STREAM cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        frame_q <= data_in;
        idx_q   <= '0;
      end else if (fire) begin
        idx_q <= at_last ? '0 : idx_q + 1'b1;
      end
    end
  end

`ifdef FMAP_UNPACK_COORD_EN
  localparam int CW = clog2w(C);

  always_ff @(posedge clk) begin
    if (rst || load || (fire && at_last)) begin
      out_row <= '0;
      out_col <= '0;
    end else if (fire) begin
      if (out_col == CW'(C - 1)) begin
        out_col <= '0;
        out_row <= out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fmap_unpacker.sv
// Self-checking bench for fmap_unpacker: vector table of frames plus reset and coordinate sequences.
module tb_fmap_unpacker;
  localparam int DW = 32;
  localparam int R  = 3;
  localparam int C  = 3;
  localparam int N  = R * C;

  typedef struct {
    logic [DW-1:0] px;
    logic          last;
    int            idx;
  } exp_t;

  typedef struct {
    logic [DW-1:0] base;
    logic [3:0]    pat;     // out_ready for STREAM cycle c is pat[c%4]
    bit            hold;    // keep in_valid high with new data during STREAM
    int            cycles;  // expected STREAM cycles until the last beat
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW*N-1:0] data_in = '0;
  logic            in_ready, out_valid, out_last;
  logic [DW-1:0]   pixel_out;
`ifdef FMAP_UNPACK_COORD_EN
  logic [1:0]      out_row, out_col;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[5];

  fmap_unpacker #(.data_width(DW), .R(R), .C(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FMAP_UNPACK_COORD_EN
    .out_row(out_row), .out_col(out_col),
`endif
    .pixel_out(pixel_out), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*N-1:0] mk(input logic [DW-1:0] b);
    logic [DW*N-1:0] f;
    for (int i = 0; i < N; i++) f[DW*i +: DW] = b + DW'(i);
    return f;
  endfunction

  task automatic push(input logic [DW-1:0] b);
    for (int i = 0; i < N; i++) sb.push_back('{px: b + DW'(i), last: (i == N-1), idx: i});
  endtask

  // Scoreboard: every valid cycle must show the head entry; a transfer pops it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("in_ready_in_stream", in_ready, 0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: pixel 0x%0h with no pixel expected", pixel_out);
      end else begin
        e = sb[0];
        check("pixel", pixel_out, e.px);
        check("last", out_last, e.last);
`ifdef FMAP_UNPACK_COORD_EN
        check("row", out_row, e.idx / C);
        check("col", out_col, e.idx % C);
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic stream(input logic [3:0] pat, input int beats, input int cycles);
    int c = 0;
    int n = 0;
    while (n < beats && c < 200) begin
      out_ready = pat[c % 4];
      if (c == 0) check("first_beat_valid", out_valid, 1);
      if (out_valid && out_ready) n++;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    check("stream_cycles", c, cycles);
  endtask

  task automatic run_frame(input vec_t v);
    check("accept_ready", in_ready, 1);
    data_in  = mk(v.base);
    in_valid = 1'b1;
    push(v.base);
    @(posedge clk); #1;
    if (v.hold) data_in = mk(v.base + 32'h100);
    else in_valid = 1'b0;
    stream(v.pat, N, v.cycles);
    check("idle_gap_ready", in_ready, 1);
    check("idle_gap_valid", out_valid, 0);
    if (v.hold) begin
      push(v.base + 32'h100);
      @(posedge clk); #1;
      in_valid = 1'b0;
      stream(4'b1111, N, N);
      check("idle_gap2_ready", in_ready, 1);
      check("idle_gap2_valid", out_valid, 0);
    end
  endtask

`ifdef FMAP_UNPACK_COORD_EN
  logic        iv2 = 1'b0, or2 = 1'b0, ir2, ov2, ol2;
  logic [47:0] d2 = 48'h050403020100;
  logic [7:0]  px2;
  logic [0:0]  row2;
  logic [1:0]  col2;

  fmap_unpacker #(.data_width(8), .R(2), .C(3)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .data_in(d2),
    .out_valid(ov2), .out_ready(or2),
    .out_row(row2), .out_col(col2),
    .pixel_out(px2), .out_last(ol2)
  );
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{base: 32'h10, pat: 4'b1111, hold: 1'b0, cycles: 9};
    vecs[1] = '{base: 32'h10, pat: 4'b1001, hold: 1'b0, cycles: 17};
    vecs[2] = '{base: 32'h20, pat: 4'b0101, hold: 1'b0, cycles: 17};
    vecs[3] = '{base: 32'h30, pat: 4'b1010, hold: 1'b0, cycles: 18};
    vecs[4] = '{base: 32'h40, pat: 4'b1111, hold: 1'b1, cycles: 9};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_last", out_last, 0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset after pixel 4 transfers, with a handshake pending in the reset cycle.
    data_in  = mk(32'h50);
    in_valid = 1'b1;
    push(32'h50);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stream(4'b1111, 5, 5);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pixel", pixel_out, 0);
    run_frame('{base: 32'h60, pat: 4'b1111, hold: 1'b0, cycles: 9});

`ifdef FMAP_UNPACK_COORD_EN
    iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    or2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("c_valid", ov2, 1);
      check("c_row", row2, k / 3);
      check("c_col", col2, k % 3);
      check("c_pixel", px2, k);
      check("c_last", ol2, k == 5);
      @(posedge clk); #1;
    end
    or2 = 1'b0;
    check("c_idle", ov2, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
